// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 control unit: state enum, opcodes,
// mux-select codes and the packed control word.
package slc3_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned NZP_W  = 3;
    localparam int unsigned WAIT_W = 3;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR,
        S_BR_TAKEN,
        S_JMP,
        S_JSR1,
        S_JSR2,
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [OP_W-1:0] OP_BR    = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OP_W-1:0] OP_JSR   = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0101;
    localparam logic [OP_W-1:0] OP_LDR   = 4'b0110;
    localparam logic [OP_W-1:0] OP_STR   = 4'b0111;
    localparam logic [OP_W-1:0] OP_NOT   = 4'b1001;
    localparam logic [OP_W-1:0] OP_JMP   = 4'b1100;
    localparam logic [OP_W-1:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1    = 2'b00;
    localparam logic [1:0] PCMUX_BUS    = 2'b01;
    localparam logic [1:0] PCMUX_MARMUX = 2'b10;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic ADDR1_PC  = 1'b0;
    localparam logic ADDR1_SR1 = 1'b1;
    localparam logic SR1_HI    = 1'b0;
    localparam logic SR1_LO    = 1'b1;
    localparam logic DR_R7     = 1'b1;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_cc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic       sr2mux;
        logic       addr1mux;
        logic       drmux;
        logic       sr1mux;
        logic       mio_en;
        logic [1:0] pcmux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_en;
        logic       mem_we;
        logic       paused;
    } ctrl_t;

    // States that hold a memory access open for MEM_WAIT cycles
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/slc3_nzp.sv
// Condition-code register (N/Z/P) loaded from the bus, plus branch-enable evaluation.
module slc3_nzp
    import slc3_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_cc,
    input  logic [WORD_W-1:0] bus,
    input  logic [NZP_W-1:0]  cond,
    output logic              ben_c
);

    logic [NZP_W-1:0] nzp;
    logic [NZP_W-1:0] nzp_next;

    always_comb begin
        nzp_next = 3'b001;
        if (bus[WORD_W-1]) begin
            nzp_next = 3'b100;
        end else if (bus == '0) begin
            nzp_next = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nzp <= '0;
        end else if (ld_cc) begin
            nzp <= nzp_next;
        end
    end

    // A zero condition field can never match, so BR with nzp=000 is a no-op
    assign ben_c = |(cond & nzp);

endmodule

// File: rtl/slc3_control.sv
// SLC-3 Moore control FSM: fetch/decode/execute sequencing with a shared
// memory wait counter and condition-code tracking.
module slc3_control
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              Continue,
    input  logic [WORD_W-1:0] IR,
    input  logic [WORD_W-1:0] bus,
    output logic              LD_MAR,
    output logic              LD_MDR,
    output logic              LD_IR,
    output logic              LD_REG,
    output logic              LD_PC,
    output logic              GatePC,
    output logic              GateMDR,
    output logic              GateALU,
    output logic              GateMARMUX,
    output logic              SR2MUX,
    output logic              ADDR1MUX,
    output logic              DRMUX,
    output logic              SR1MUX,
    output logic              MIO_EN,
    output logic [1:0]        PCMUX,
    output logic [1:0]        ADDR2MUX,
    output logic [1:0]        ALUK,
    output logic              Mem_EN,
    output logic              Mem_WE,
    output logic              paused
);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done_c;
    logic              ben_c;
    ctrl_t             ctrl_c;
    logic [OP_W-1:0]   opcode;
    logic              unused_ir_c;

    assign opcode      = IR[15:12];
    assign wait_done_c = (wait_cnt == '0);
    assign unused_ir_c = ^{IR[8:6], IR[4:0]};

    // State register and memory wait counter, reloaded on entry to any memory state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_HALTED;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (is_mem_state(state_next) && (state_next != state)) begin
                wait_cnt <= WAIT_W'(MEM_WAIT - 1);
            end else if (!wait_done_c) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_HALTED:   if (Run) state_next = S_FETCH1;
            S_FETCH1:   state_next = S_FETCH2;
            S_FETCH2:   if (wait_done_c) state_next = S_FETCH3;
            S_FETCH3:   state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD:   state_next = S_ADD;
                    OP_AND:   state_next = S_AND;
                    OP_NOT:   state_next = S_NOT;
                    OP_BR:    state_next = S_BR;
                    OP_JMP:   state_next = S_JMP;
                    OP_JSR:   state_next = S_JSR1;
                    OP_LDR:   state_next = S_LDR1;
                    OP_STR:   state_next = S_STR1;
                    OP_PAUSE: state_next = S_PAUSE1;
                    default:  state_next = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: state_next = S_FETCH1;
            S_BR:       state_next = ben_c ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN: state_next = S_FETCH1;
            S_JMP:      state_next = S_FETCH1;
            S_JSR1:     state_next = S_JSR2;
            S_JSR2:     state_next = S_FETCH1;
            S_LDR1:     state_next = S_LDR2;
            S_LDR2:     if (wait_done_c) state_next = S_LDR3;
            S_LDR3:     state_next = S_FETCH1;
            S_STR1:     state_next = S_STR2;
            S_STR2:     state_next = S_STR3;
            S_STR3:     if (wait_done_c) state_next = S_FETCH1;
            S_PAUSE1:   if (Continue) state_next = S_PAUSE2;
            S_PAUSE2:   if (!Continue) state_next = S_FETCH1;
            default:    state_next = S_HALTED;
        endcase
    end

    // Moore output decode: control word depends on state and IR only
    always_comb begin
        ctrl_c = '0;
        case (state)
            S_FETCH1: begin
                ctrl_c.gate_pc = 1'b1;
                ctrl_c.ld_mar  = 1'b1;
                ctrl_c.pcmux   = PCMUX_PC1;
                ctrl_c.ld_pc   = 1'b1;
            end
            S_FETCH2, S_LDR2: begin
                ctrl_c.mem_en = 1'b1;
                ctrl_c.mio_en = 1'b1;
                ctrl_c.ld_mdr = 1'b1;
            end
            S_FETCH3: begin
                ctrl_c.gate_mdr = 1'b1;
                ctrl_c.ld_ir    = 1'b1;
            end
            S_ADD, S_AND, S_NOT: begin
                ctrl_c.gate_alu = 1'b1;
                ctrl_c.ld_reg   = 1'b1;
                ctrl_c.ld_cc    = 1'b1;
                ctrl_c.sr1mux   = SR1_LO;
                if (state == S_ADD) begin
                    ctrl_c.aluk   = ALUK_ADD;
                    ctrl_c.sr2mux = IR[5];
                end else if (state == S_AND) begin
                    ctrl_c.aluk   = ALUK_AND;
                    ctrl_c.sr2mux = IR[5];
                end else begin
                    ctrl_c.aluk = ALUK_NOT;
                end
            end
            S_BR_TAKEN: begin
                ctrl_c.addr1mux = ADDR1_PC;
                ctrl_c.addr2mux = ADDR2_OFF9;
                ctrl_c.pcmux    = PCMUX_MARMUX;
                ctrl_c.ld_pc    = 1'b1;
            end
            S_JMP: begin
                ctrl_c.sr1mux   = SR1_LO;
                ctrl_c.addr1mux = ADDR1_SR1;
                ctrl_c.addr2mux = ADDR2_ZERO;
                ctrl_c.pcmux    = PCMUX_MARMUX;
                ctrl_c.ld_pc    = 1'b1;
            end
            S_JSR1: begin
                ctrl_c.gate_pc = 1'b1;
                ctrl_c.drmux   = DR_R7;
                ctrl_c.ld_reg  = 1'b1;
            end
            S_JSR2: begin
                ctrl_c.addr2mux = ADDR2_OFF11;
                ctrl_c.addr1mux = ADDR1_PC;
                ctrl_c.pcmux    = PCMUX_MARMUX;
                ctrl_c.ld_pc    = 1'b1;
            end
            S_LDR1, S_STR1: begin
                ctrl_c.gate_marmux = 1'b1;
                ctrl_c.addr1mux    = ADDR1_SR1;
                ctrl_c.addr2mux    = ADDR2_OFF6;
                ctrl_c.sr1mux      = SR1_LO;
                ctrl_c.ld_mar      = 1'b1;
            end
            S_LDR3: begin
                ctrl_c.gate_mdr = 1'b1;
                ctrl_c.ld_reg   = 1'b1;
                ctrl_c.ld_cc    = 1'b1;
            end
            S_STR2: begin
                ctrl_c.sr1mux   = SR1_HI;
                ctrl_c.aluk     = ALUK_PASS;
                ctrl_c.gate_alu = 1'b1;
                ctrl_c.ld_mdr   = 1'b1;
                ctrl_c.mio_en   = 1'b0;
            end
            S_STR3: begin
                ctrl_c.mem_en = 1'b1;
                ctrl_c.mem_we = 1'b1;
            end
            S_PAUSE1, S_PAUSE2: begin
                ctrl_c.paused = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

    slc3_nzp u_nzp (
        .clk   (Clk),
        .reset (Reset),
        .ld_cc (ctrl_c.ld_cc),
        .bus   (bus),
        .cond  (IR[11:9]),
        .ben_c (ben_c)
    );

    assign LD_MAR     = ctrl_c.ld_mar;
    assign LD_MDR     = ctrl_c.ld_mdr;
    assign LD_IR      = ctrl_c.ld_ir;
    assign LD_REG     = ctrl_c.ld_reg;
    assign LD_PC      = ctrl_c.ld_pc;
    assign GatePC     = ctrl_c.gate_pc;
    assign GateMDR    = ctrl_c.gate_mdr;
    assign GateALU    = ctrl_c.gate_alu;
    assign GateMARMUX = ctrl_c.gate_marmux;
    assign SR2MUX     = ctrl_c.sr2mux;
    assign ADDR1MUX   = ctrl_c.addr1mux;
    assign DRMUX      = ctrl_c.drmux;
    assign SR1MUX     = ctrl_c.sr1mux;
    assign MIO_EN     = ctrl_c.mio_en;
    assign PCMUX      = ctrl_c.pcmux;
    assign ADDR2MUX   = ctrl_c.addr2mux;
    assign ALUK       = ctrl_c.aluk;
    assign Mem_EN     = ctrl_c.mem_en;
    assign Mem_WE     = ctrl_c.mem_we;
    assign paused     = ctrl_c.paused;

endmodule

// File: tb/tb_slc3_control.sv
// Directed bench for slc3_control: walks each instruction flow and checks
// control outputs, condition codes, memory timing and reset behaviour.
module tb_slc3_control;

    localparam int unsigned MW = 2;

    logic        clk = 1'b0;
    logic        Reset, Run, Continue;
    logic [15:0] IR, bus;
    logic        LD_MAR, LD_MDR, LD_IR, LD_REG, LD_PC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic        SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        Mem_EN, Mem_WE, paused;
    logic [22:0] all_outs;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n;

    slc3_control #(.MEM_WAIT(MW)) dut (
        .Clk(clk), .Reset(Reset), .Run(Run), .Continue(Continue), .IR(IR), .bus(bus),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_REG(LD_REG), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
        .MIO_EN(MIO_EN), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_EN(Mem_EN), .Mem_WE(Mem_WE), .paused(paused)
    );

    always #5 clk = ~clk;

    assign all_outs = {LD_MAR, LD_MDR, LD_IR, LD_REG, LD_PC, GatePC, GateMDR, GateALU,
                       GateMARMUX, SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN, PCMUX,
                       ADDR2MUX, ALUK, Mem_EN, Mem_WE, paused};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH1, run the fetch sequence with the given instruction; ends in DECODE
    task automatic fetch(input logic [15:0] ir);
        IR = ir;
        check("fetch1_gatepc", GatePC, 1);
        repeat (MW) begin
            tick();
            check("fetch2_mem_en", Mem_EN, 1);
        end
        tick();
        check("fetch3_ld_ir", LD_IR, 1);
        tick();
    endtask

    // Bus-driver exclusivity and store/MDR separation on every cycle
    always @(negedge clk) begin
        n_checks++;
        assert ($onehot0({GatePC, GateMDR, GateALU, GateMARMUX})) else begin
            n_errors++;
            $error("FAIL gate_onehot: observed %b expected onehot0",
                   {GatePC, GateMDR, GateALU, GateMARMUX});
        end
        n_checks++;
        assert (!(Mem_WE && LD_MDR)) else begin
            n_errors++;
            $error("FAIL we_with_ld_mdr: observed %b expected 0", Mem_WE & LD_MDR);
        end
    end

    initial begin
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0; IR = 16'h0000; bus = 16'h0000;
        tick(); tick();
        Reset = 1'b0;
        check("reset_outs", all_outs, 0);
        check("reset_nzp", dut.u_nzp.nzp, 3'b000);
        tick();
        check("halted_idle", all_outs, 0);

        // Run -> FETCH1 on the next edge; LD_IR MW+1 cycles later
        Run = 1'b1;
        tick();
        Run = 1'b0;
        IR  = 16'h1042;
        check("fetch1_gatepc", GatePC, 1);
        check("fetch1_ld_mar", LD_MAR, 1);
        check("fetch1_ld_pc", LD_PC, 1);
        check("fetch1_pcmux", PCMUX, 2'b00);
        tick();
        check("fetch2a_mem", {Mem_EN, MIO_EN, LD_MDR, LD_IR}, 4'b1110);
        tick();
        check("fetch2b_mem", {Mem_EN, LD_IR}, 2'b10);
        tick();
        check("fetch3", {LD_IR, GateMDR}, 2'b11);
        tick();
        check("decode_outs", all_outs, 0);

        // ADD R0,R1,R2 with negative result
        tick();
        check("add_ctl", {GateALU, LD_REG, SR2MUX, SR1MUX}, 4'b1101);
        check("add_aluk", ALUK, 2'b00);
        bus = 16'hFFFF;
        tick();
        check("add_nzp", dut.u_nzp.nzp, 3'b100);

        // AND R0,R0,#1 with zero result
        fetch(16'h5021);
        tick();
        check("and_aluk", ALUK, 2'b01);
        check("and_sr2mux", SR2MUX, 1);
        bus = 16'h0000;
        tick();
        check("and_nzp", dut.u_nzp.nzp, 3'b010);

        // BRnp with Z set: not taken
        fetch(16'h0A05);
        tick();
        check("brnp_ld_pc", LD_PC, 0);
        tick();
        check("brnp_back_fetch", GatePC, 1);

        // BRz with Z set: taken
        fetch(16'h0405);
        tick();
        tick();
        check("brz_taken", {LD_PC, PCMUX, ADDR2MUX, ADDR1MUX}, 6'b1_10_10_0);
        tick();

        // NOT with positive result
        fetch(16'h903F);
        tick();
        check("not_aluk", {GateALU, ALUK}, 3'b1_10);
        bus = 16'h0005;
        tick();
        check("not_nzp", dut.u_nzp.nzp, 3'b001);

        // BR with empty condition field never taken
        fetch(16'h0005);
        tick();
        tick();
        check("br000_not_taken", {GatePC, LD_MAR}, 2'b11);

        // BRp with P set: taken
        fetch(16'h0205);
        tick();
        tick();
        check("brp_taken", LD_PC, 1);
        tick();

        // JMP R7
        fetch(16'hC1C0);
        tick();
        check("jmp_ctl", {LD_PC, PCMUX, ADDR1MUX, ADDR2MUX, SR1MUX}, 7'b1_10_1_00_1);
        tick();

        // JSR
        fetch(16'h4800);
        tick();
        check("jsr1_ctl", {GatePC, DRMUX, LD_REG, LD_PC}, 4'b1110);
        tick();
        check("jsr2_ctl", {LD_PC, PCMUX, ADDR2MUX, ADDR1MUX}, 6'b1_10_11_0);
        tick();

        // LDR full path, loaded value negative
        fetch(16'h6042);
        tick();
        check("ldr1_ctl", {GateMARMUX, LD_MAR, ADDR1MUX, ADDR2MUX, SR1MUX}, 6'b1_1_1_01_1);
        tick();
        check("ldr2a_mem", {Mem_EN, MIO_EN, Mem_WE}, 3'b110);
        tick();
        check("ldr2b_mem", Mem_EN, 1);
        tick();
        check("ldr3_ctl", {GateMDR, LD_REG}, 2'b11);
        bus = 16'h8000;
        tick();
        check("ldr_nzp", dut.u_nzp.nzp, 3'b100);

        // STR: write strobe held exactly MW cycles
        fetch(16'h7042);
        tick();
        check("str1_ctl", {GateMARMUX, LD_MAR, ADDR2MUX}, 4'b11_01);
        tick();
        check("str2_ctl", {GateALU, LD_MDR, ALUK, SR1MUX, MIO_EN, Mem_EN}, 7'b1_1_11_0_0_0);
        tick();
        n = 0;
        while (Mem_WE && n < 10) begin
            check("str3_mem_en", Mem_EN, 1);
            n++;
            tick();
        end
        check("str_we_cycles", n, MW);
        check("str_back_fetch", GatePC, 1);

        // PAUSE handshake
        fetch(16'hD00F);
        tick();
        check("pause1", paused, 1);
        tick(); tick();
        check("pause1_hold", paused, 1);
        Continue = 1'b1;
        tick();
        check("pause2", paused, 1);
        tick(); tick();
        check("pause2_hold", {paused, GatePC}, 2'b10);
        Continue = 1'b0;
        tick();
        check("pause_release", {paused, GatePC}, 2'b01);

        // Unsupported opcode behaves as NOP
        fetch(16'h2000);
        tick();
        check("nop_back_fetch", GatePC, 1);

        // Reset in the middle of a load access
        fetch(16'h6042);
        tick();
        tick();
        check("ldr2_before_reset", Mem_EN, 1);
        Reset = 1'b1;
        tick();
        check("midreset_outs", all_outs, 0);
        check("midreset_nzp", dut.u_nzp.nzp, 3'b000);
        Reset = 1'b0;
        tick();
        check("after_reset_outs", all_outs, 0);
        tick();
        check("halted_stays", all_outs, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
